if_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, issues one word fetch at a time to instruction memory over a request/response handshake, and presents `instruction_out`, `PCNow_out`, `PCNext4_out` to IF/ID. Honors the same `Write` stall signal as IF/ID, and accepts PC redirects from branch/jump resolution. Emits NOP bubbles (32'h0) while no instruction is ready.

---
 rtl/if_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage with one outstanding imem request and registered IF/ID outputs.
// Define IF_STAGE_ALIGN_CHECK_EN to raise fetch_fault on a misaligned PC instead of ignoring the low bits.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] PCNow_out,
    output logic [31:0] PCNext4_out,
    output logic        valid_out,
    output logic        fetch_fault
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_now_q, pc_now_d;
    logic [31:0] pc_next4_q, pc_next4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        misaligned;
    logic        accept;

`ifdef IF_STAGE_ALIGN_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign imem_req        = (state_q == S_REQ) && !misaligned && !rst;
    assign imem_addr       = {pc_q[31:2], 2'b00};
    assign accept          = imem_req && imem_ready;
    assign instruction_out = instr_q;
    assign PCNow_out       = pc_now_q;
    assign PCNext4_out     = pc_next4_q;
    assign valid_out       = valid_q;
    assign fetch_fault     = fault_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        pc_now_d   = pc_now_q;
        pc_next4_d = pc_next4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    // A redirect also releases a sitting fault presentation.
                    pc_d       = redirect_pc;
                    instr_d    = 32'h0;
                    pc_now_d   = 32'h0;
                    pc_next4_d = 32'h0;
                    valid_d    = 1'b0;
                    fault_d    = 1'b0;
                    if (accept) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (misaligned) begin
                    fault_d    = 1'b1;
                    valid_d    = 1'b1;
                    instr_d    = 32'h0;
                    pc_now_d   = pc_q;
                    pc_next4_d = pc_q + 32'd4;
                end else if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d    = imem_rdata;
                        pc_now_d   = pc_q;
                        pc_next4_d = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect || Write) begin
                    pc_d       = redirect ? redirect_pc : pc_q + 32'd4;
                    instr_d    = 32'h0;
                    pc_now_d   = 32'h0;
                    pc_next4_d = 32'h0;
                    valid_d    = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= 32'h0;
            pc_now_q   <= 32'h0;
            pc_next4_q <= 32'h0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            pc_now_q   <= pc_now_d;
            pc_next4_q <= pc_next4_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end
endmodule
